// File: rtl/lbp_pkg.sv
// Shared types and constants for the LBP engine: image geometry, FSM states,
// neighbour slot numbering and the {row, col} pixel address helper.
package lbp_pkg;

  localparam int unsigned IMG_W   = 128;
  localparam int unsigned ADDR_W  = 14;

  localparam logic [6:0] ROW_FIRST = 7'd1;
  localparam logic [6:0] ROW_LAST  = 7'(IMG_W - 2);
  localparam logic [6:0] COL_LAST  = 7'(IMG_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    OUT,
    DONE
  } state_e;

  // Neighbour slots; slot p becomes bit p of the code
  localparam int unsigned NB_TL = 0;
  localparam int unsigned NB_T  = 1;
  localparam int unsigned NB_TR = 2;
  localparam int unsigned NB_L  = 3;
  localparam int unsigned NB_R  = 4;
  localparam int unsigned NB_BL = 5;
  localparam int unsigned NB_B  = 6;
  localparam int unsigned NB_BR = 7;

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [6:0] row,
                                                 input logic [6:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/lbp_compare.sv
// Combinational LBP code: bit p is set when neighbour p >= centre (unsigned).
module lbp_compare import lbp_pkg::*; (
  input  logic [63:0] nb_i,
  input  logic [7:0]  center_i,
  output logic [7:0]  code_o
);

  always_comb begin
    code_o = '0;
    for (int unsigned p = 0; p < 8; p++) begin
      code_o[p] = (nb_i[p*8 +: 8] >= center_i);
    end
  end

endmodule

// File: rtl/lbp_engine.sv
// LBP engine: streams 3-pixel columns from the gray memory into a sliding 3x3
// window and writes one code per interior pixel to the result memory.
module lbp_engine import lbp_pkg::*; (
  input  logic              clk,
  input  logic              reset,
  input  logic              gray_ready,
  output logic              gray_req,
  output logic [ADDR_W-1:0] gray_addr,
  input  logic [7:0]        gray_data,
  output logic              lbp_valid,
  output logic [ADDR_W-1:0] lbp_addr,
  output logic [7:0]        lbp_data,
  output logic              finish
);

  state_e state_q, state_d;
  logic   issue, last_issue;

  // Read-issue position: centre row, column, phase (0=top, 1=mid, 2=bottom)
  logic [6:0] rd_r_q, rd_x_q, rd_row;
  logic [1:0] rd_ph_q;

  // Tag travelling with the outstanding read
  logic              req_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [6:0]        cap_r_q, cap_x_q;
  logic [1:0]        cap_ph_q;

  // New column being assembled; w1 = column x-2, w2 = column x-1
  logic [7:0] top_q, mid_q;
  logic [7:0] w1_top_q, w1_mid_q, w1_bot_q;
  logic [7:0] w2_top_q, w2_mid_q, w2_bot_q;

  logic              valid_q, finish_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [7:0]        out_data_q;

  logic [63:0] nb;
  logic [7:0]  code;

  assign rd_row = rd_r_q + {5'b0, rd_ph_q} - 7'd1;

  always_comb begin
    state_d    = state_q;
    issue      = 1'b0;
    last_issue = (rd_r_q == ROW_LAST) && (rd_x_q == COL_LAST) && (rd_ph_q == 2'd2);
    unique case (state_q)
      IDLE: begin
        if (gray_ready) begin
          state_d = READ;
          issue   = 1'b1;
        end
      end
      READ: begin
        issue = 1'b1;
        if (last_issue) state_d = OUT;
      end
      // Drain: last bottom read is in flight, finish follows its result pulse
      OUT: begin
        if (valid_q) state_d = DONE;
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Window taps: the bottom-right pixel is the read being captured this edge
  always_comb begin
    nb                 = '0;
    nb[NB_TL*8 +: 8]   = w1_top_q;
    nb[NB_T*8  +: 8]   = w2_top_q;
    nb[NB_TR*8 +: 8]   = top_q;
    nb[NB_L*8  +: 8]   = w1_mid_q;
    nb[NB_R*8  +: 8]   = mid_q;
    nb[NB_BL*8 +: 8]   = w1_bot_q;
    nb[NB_B*8  +: 8]   = w2_bot_q;
    nb[NB_BR*8 +: 8]   = gray_data;
  end

  lbp_compare u_compare (
    .nb_i     (nb),
    .center_i (w2_mid_q),
    .code_o   (code)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_r_q     <= ROW_FIRST;
      rd_x_q     <= '0;
      rd_ph_q    <= '0;
      req_q      <= 1'b0;
      req_addr_q <= '0;
      cap_r_q    <= '0;
      cap_x_q    <= '0;
      cap_ph_q   <= '0;
      top_q      <= '0;
      mid_q      <= '0;
      w1_top_q   <= '0;
      w1_mid_q   <= '0;
      w1_bot_q   <= '0;
      w2_top_q   <= '0;
      w2_mid_q   <= '0;
      w2_bot_q   <= '0;
      valid_q    <= 1'b0;
      out_addr_q <= '0;
      out_data_q <= '0;
      finish_q   <= 1'b0;
    end else begin
      req_q <= issue;
      if (issue) begin
        req_addr_q <= pix_addr(rd_row, rd_x_q);
        cap_r_q    <= rd_r_q;
        cap_x_q    <= rd_x_q;
        cap_ph_q   <= rd_ph_q;
        if (rd_ph_q == 2'd2) begin
          rd_ph_q <= '0;
          if (rd_x_q == COL_LAST) begin
            rd_x_q <= '0;
            rd_r_q <= rd_r_q + 7'd1;
          end else begin
            rd_x_q <= rd_x_q + 7'd1;
          end
        end else begin
          rd_ph_q <= rd_ph_q + 2'd1;
        end
      end

      valid_q <= 1'b0;
      if (req_q) begin
        unique case (cap_ph_q)
          2'd0:    top_q <= gray_data;
          2'd1:    mid_q <= gray_data;
          default: begin
            w1_top_q <= w2_top_q;
            w1_mid_q <= w2_mid_q;
            w1_bot_q <= w2_bot_q;
            w2_top_q <= top_q;
            w2_mid_q <= mid_q;
            w2_bot_q <= gray_data;
            if (cap_x_q >= 7'd2) begin
              valid_q    <= 1'b1;
              out_addr_q <= pix_addr(cap_r_q, cap_x_q - 7'd1);
              out_data_q <= code;
            end
          end
        endcase
      end

      if (state_d == DONE) finish_q <= 1'b1;
    end
  end

  assign gray_req  = req_q;
  assign gray_addr = req_addr_q;
  assign lbp_valid = valid_q;
  assign lbp_addr  = out_addr_q;
  assign lbp_data  = out_data_q;
  assign finish    = finish_q;

endmodule

// File: tb/tb_lbp_engine.sv
// Bench for lbp_engine: gray memory model, raster-order scoreboard of expected
// codes from a software LBP model, result memory for border/spot checks.
module tb_lbp_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        gray_ready;
  logic        gray_req;
  logic [13:0] gray_addr;
  logic [7:0]  gray_data;
  logic        lbp_valid;
  logic [13:0] lbp_addr;
  logic [7:0]  lbp_data;
  logic        finish;

  always #5 clk = ~clk;

  lbp_engine dut (
    .clk        (clk),
    .reset      (reset),
    .gray_ready (gray_ready),
    .gray_req   (gray_req),
    .gray_addr  (gray_addr),
    .gray_data  (gray_data),
    .lbp_valid  (lbp_valid),
    .lbp_addr   (lbp_addr),
    .lbp_data   (lbp_data),
    .finish     (finish)
  );

  logic [7:0] img [16384];
  logic [7:0] res [16384];

  typedef struct packed {
    logic [13:0] addr;
    logic [7:0]  code;
  } exp_t;
  exp_t sb[$];

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Gray memory: data for the registered request is valid by the next rising edge
  always @(negedge clk) gray_data = gray_req ? img[gray_addr] : 8'hzz;

  function automatic logic [7:0] ref_lbp(input int r, input int c);
    logic [7:0] v;
    int p;
    v = '0;
    p = 0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (dr != 0 || dc != 0) begin
          if (img[(r + dr) * 128 + (c + dc)] >= img[r * 128 + c]) v[p] = 1'b1;
          p++;
        end
      end
    end
    return v;
  endfunction

  // Rows 0..31 flat 100 with a dark pixel at (5,5), rows 32..63 ramp, rest random
  task automatic build_image();
    for (int r = 0; r < 128; r++) begin
      for (int c = 0; c < 128; c++) begin
        if (r < 32)      img[r * 128 + c] = 8'd100;
        else if (r < 64) img[r * 128 + c] = 8'(c);
        else             img[r * 128 + c] = 8'($urandom_range(0, 255));
      end
    end
    img[5 * 128 + 5] = 8'd0;
  endtask

  task automatic load_scoreboard();
    sb.delete();
    for (int i = 0; i < 16384; i++) res[i] = 8'd0;
    for (int r = 1; r <= 126; r++) begin
      for (int c = 1; c <= 126; c++) begin
        sb.push_back({14'(r * 128 + c), ref_lbp(r, c)});
      end
    end
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    gray_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (gray_req  !== 1'b0)  begin n_err++; $display("FAIL reset_gray_req: got %b want 0", gray_req); end
    n_cmp++; if (gray_addr !== 14'd0) begin n_err++; $display("FAIL reset_gray_addr: got %0d want 0", gray_addr); end
    n_cmp++; if (lbp_valid !== 1'b0)  begin n_err++; $display("FAIL reset_lbp_valid: got %b want 0", lbp_valid); end
    n_cmp++; if (lbp_addr  !== 14'd0) begin n_err++; $display("FAIL reset_lbp_addr: got %0d want 0", lbp_addr); end
    n_cmp++; if (lbp_data  !== 8'd0)  begin n_err++; $display("FAIL reset_lbp_data: got %0d want 0", lbp_data); end
    n_cmp++; if (finish    !== 1'b0)  begin n_err++; $display("FAIL reset_finish: got %b want 0", finish); end
  endtask

  task automatic test_ready_wait();
    logic [13:0] exp_addr [3];
    bit          seen;
    exp_addr[0] = 14'd0;
    exp_addr[1] = 14'd128;
    exp_addr[2] = 14'd256;
    build_image();
    load_scoreboard();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_cmp++;
      if (gray_req !== 1'b0) begin n_err++; $display("FAIL idle_no_req: cycle %0d got %b want 0", i, gray_req); end
    end
    gray_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (gray_req === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin n_err++; $display("FAIL first_req: got no request want request within 10 cycles"); end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      n_cmp++;
      if (gray_req !== 1'b1 || gray_addr !== exp_addr[k]) begin
        n_err++;
        $display("FAIL first_col_read%0d: got req=%b addr=%0d want req=1 addr=%0d", k, gray_req, gray_addr, exp_addr[k]);
      end
    end
    // Mid-frame drop of gray_ready must not stall the sweep
    gray_ready = 1'b0;
  endtask

  task automatic test_mid_frame_reset();
    exp_t e;
    bit   hit;
    hit = 1'b0;
    for (int i = 0; i < 30000 && !hit; i++) begin
      @(negedge clk);
      if (lbp_valid === 1'b1) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL partial_extra: got addr=%0d want no pulse", lbp_addr);
        end else begin
          e = sb.pop_front();
          if (lbp_addr !== e.addr || lbp_data !== e.code) begin
            n_err++;
            $display("FAIL partial_code: got addr=%0d data=%0d want addr=%0d data=%0d", lbp_addr, lbp_data, e.addr, e.code);
          end
        end
        if (lbp_addr[13:7] == 7'd60) hit = 1'b1;
      end
    end
    n_cmp++;
    if (!hit) begin n_err++; $display("FAIL reach_row60: got timeout want pulse on row 60"); end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (gray_req !== 1'b0 || gray_addr !== 14'd0 || lbp_valid !== 1'b0 ||
        lbp_addr !== 14'd0 || lbp_data !== 8'd0 || finish !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_outputs: got req=%b ga=%0d v=%b la=%0d ld=%0d fin=%b want all 0",
               gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish);
    end
    @(negedge clk);
    load_scoreboard();
    reset      = 1'b0;
    gray_ready = 1'b1;
  endtask

  task automatic test_full_frame();
    exp_t        e;
    int          cyc, last_valid_cyc, finish_cyc, pulses, bad_border;
    logic [13:0] spot_addr [12];
    logic [7:0]  spot_code [12];
    spot_addr[0]  = 14'(5 * 128 + 5);  spot_code[0]  = 8'd255;
    spot_addr[1]  = 14'(4 * 128 + 4);  spot_code[1]  = 8'd127;
    spot_addr[2]  = 14'(4 * 128 + 5);  spot_code[2]  = 8'd191;
    spot_addr[3]  = 14'(4 * 128 + 6);  spot_code[3]  = 8'd223;
    spot_addr[4]  = 14'(5 * 128 + 4);  spot_code[4]  = 8'd239;
    spot_addr[5]  = 14'(5 * 128 + 6);  spot_code[5]  = 8'd247;
    spot_addr[6]  = 14'(6 * 128 + 4);  spot_code[6]  = 8'd251;
    spot_addr[7]  = 14'(6 * 128 + 5);  spot_code[7]  = 8'd253;
    spot_addr[8]  = 14'(6 * 128 + 6);  spot_code[8]  = 8'd254;
    spot_addr[9]  = 14'(10 * 128 + 10); spot_code[9] = 8'd255;
    spot_addr[10] = 14'(40 * 128 + 40); spot_code[10] = 8'd214;
    spot_addr[11] = 14'(62 * 128 + 126); spot_code[11] = 8'd214;
    pulses = 0; last_valid_cyc = -10; finish_cyc = -1;
    for (cyc = 0; cyc < 52000 && finish_cyc < 0; cyc++) begin
      @(negedge clk);
      if (finish === 1'b1) finish_cyc = cyc;
      if (lbp_valid === 1'b1) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL frame_extra: got addr=%0d want no pulse", lbp_addr);
        end else begin
          e = sb.pop_front();
          if (lbp_addr !== e.addr || lbp_data !== e.code) begin
            n_err++;
            $display("FAIL frame_code: got addr=%0d data=%0d want addr=%0d data=%0d", lbp_addr, lbp_data, e.addr, e.code);
          end
        end
        res[lbp_addr] = lbp_data;
        pulses++;
        last_valid_cyc = cyc;
      end
    end
    n_cmp++;
    if (pulses != 15876) begin n_err++; $display("FAIL pulse_count: got %0d want 15876", pulses); end
    n_cmp++;
    if (finish_cyc != last_valid_cyc + 1) begin
      n_err++; $display("FAIL finish_timing: got cycle %0d want %0d", finish_cyc, last_valid_cyc + 1);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (finish !== 1'b1 || gray_req !== 1'b0 || lbp_valid !== 1'b0) begin
        n_err++;
        $display("FAIL done_hold: got fin=%b req=%b v=%b want fin=1 req=0 v=0", finish, gray_req, lbp_valid);
      end
    end
    bad_border = 0;
    for (int k = 0; k < 128; k++) begin
      if (res[k] != 0 || res[127 * 128 + k] != 0 || res[k * 128] != 0 || res[k * 128 + 127] != 0) bad_border++;
    end
    n_cmp++;
    if (bad_border != 0) begin n_err++; $display("FAIL border_zero: got %0d nonzero want 0", bad_border); end
    for (int k = 0; k < 12; k++) begin
      n_cmp++;
      if (res[spot_addr[k]] !== spot_code[k]) begin
        n_err++;
        $display("FAIL spot_code%0d: got %0d want %0d at addr %0d", k, res[spot_addr[k]], spot_code[k], spot_addr[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ready_wait();
    test_mid_frame_reset();
    test_full_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
